// File: rtl/float_pkg.sv
// Shared definitions for the pipelined ExMy adder: format widths, field helpers and
// the stage-register structs. The stage structs are sized from FpExpW/FpManW, so a
// different format is selected here and the adder's parameters follow these defaults.
package float_pkg;

  localparam int unsigned FpExpW = 4;
  localparam int unsigned FpManW = 3;
  localparam int unsigned FpW    = 1 + FpExpW + FpManW;
  // Hidden bit + stored mantissa + guard/round/sticky.
  localparam int unsigned ExtW   = FpManW + 4;
  // ExtW plus a carry bit.
  localparam int unsigned SumW   = ExtW + 1;
  localparam int unsigned LzW    = $clog2(ExtW + 1);

  function automatic int exp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max(input int unsigned exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic logic get_sign(input logic [FpW-1:0] x);
    return x[FpW-1];
  endfunction

  function automatic logic [FpExpW-1:0] get_exp(input logic [FpW-1:0] x);
    return x[FpW-2 -: FpExpW];
  endfunction

  function automatic logic [FpManW-1:0] get_man(input logic [FpW-1:0] x);
    return x[FpManW-1:0];
  endfunction

  function automatic logic [FpW-1:0] pack_fp(input logic s, input logic [FpExpW-1:0] e,
                                             input logic [FpManW-1:0] m);
    return {s, e, m};
  endfunction

  // Aligned operands: larger magnitude in *_l, smaller one already shifted.
  typedef struct packed {
    logic              sign_l;
    logic              sign_s;
    logic              zero_sign;  // sign to use if both inputs were zero
    logic [FpExpW-1:0] exp_l;
    logic [ExtW-1:0]   man_l;
    logic [ExtW-1:0]   man_s;
  } s1_reg_t;

  // Raw magnitude sum before normalisation.
  typedef struct packed {
    logic              sign;
    logic              zero_sign;
    logic [FpExpW-1:0] exp;
    logic [SumW-1:0]   sum;
  } s2_reg_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Scan upward so the highest set bit gives the final count.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/float_adder_pipe.sv
// Three-stage ExMy adder/subtractor with valid/ready flow control.
// S1 aligns, S2 adds, S3 normalises, rounds and saturates into the output register.
// Define FLOAT_ADDER_RNE_EN for round-to-nearest-even; otherwise results truncate.
module float_adder_pipe
  import float_pkg::*;
#(
  parameter int unsigned EXP_W = FpExpW,
  parameter int unsigned MAN_W = FpManW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sub,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W+MAN_W:0] out_y,
  output logic               out_ovf
);

  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3;
  s1_reg_t s1_d, s1_q;
  s2_reg_t s2_d, s2_q;

  // Each stage loads when empty or when its content moves downstream.
  assign adv3      = !v3_q || out_ready;
  assign adv2      = !v2_q || adv3;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = v3_q;

  // ---------------- S1: order by magnitude and align the smaller operand
  logic             sign_a, sign_b, zero_a, zero_b, swap;
  logic             sign_l, sign_s, zero_l, zero_s;
  logic [EXP_W-1:0] exp_a, exp_b, exp_l, exp_s, exp_d;
  logic [MAN_W-1:0] man_a, man_b, man_l, man_s;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
  logic [ExtW-1:0]  ext_s, lost_mask, aligned;

  // Zero operands compare as magnitude 0 so the nonzero one always becomes "larger".
  always_comb begin
    sign_a = get_sign(in_a);
    sign_b = get_sign(in_b) ^ in_sub;
    exp_a  = get_exp(in_a);
    exp_b  = get_exp(in_b);
    man_a  = get_man(in_a);
    man_b  = get_man(in_b);
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);
    mag_a  = zero_a ? '0 : {exp_a, man_a};
    mag_b  = zero_b ? '0 : {exp_b, man_b};
    swap   = (mag_b > mag_a);
    sign_l = swap ? sign_b : sign_a;
    sign_s = swap ? sign_a : sign_b;
    exp_l  = swap ? exp_b : exp_a;
    exp_s  = swap ? exp_a : exp_b;
    man_l  = swap ? man_b : man_a;
    man_s  = swap ? man_a : man_b;
    zero_l = swap ? zero_b : zero_a;
    zero_s = swap ? zero_a : zero_b;
    exp_d  = exp_l - exp_s;
    ext_s  = {1'b1, man_s, 3'b000};
    lost_mask = (ExtW'(1) << exp_d) - ExtW'(1);
    if (zero_s) begin
      aligned = '0;
    end else if (int'(exp_d) >= int'(ExtW) - 1) begin
      aligned = ExtW'(1);
    end else begin
      aligned    = ext_s >> exp_d;
      aligned[0] = aligned[0] | (|(ext_s & lost_mask));
    end
    s1_d.sign_l    = sign_l;
    s1_d.sign_s    = sign_s;
    s1_d.zero_sign = zero_a & zero_b & sign_a & sign_b;
    s1_d.exp_l     = exp_l;
    s1_d.man_l     = zero_l ? '0 : {1'b1, man_l, 3'b000};
    s1_d.man_s     = aligned;
  end

  // S1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // ---------------- S2: magnitude add/subtract (man_l >= man_s by construction)
  always_comb begin
    s2_d.sign      = s1_q.sign_l;
    s2_d.zero_sign = s1_q.zero_sign;
    s2_d.exp       = s1_q.exp_l;
    if (s1_q.sign_l ^ s1_q.sign_s) s2_d.sum = {1'b0, s1_q.man_l} - {1'b0, s1_q.man_s};
    else                           s2_d.sum = {1'b0, s1_q.man_l} + {1'b0, s1_q.man_s};
  end

  // S2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      s2_q <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) s2_q <= s2_d;
    end
  end

  // ---------------- S3: normalise, round, saturate
  logic [LzW-1:0]     lz;
  logic [ExtW-1:0]    norm;
  logic [MAN_W-1:0]   man_out;
  logic [EXP_W+MAN_W:0] y_d;
  logic               ovf_d;
  int                 exp_n, exp_r;

  fp_lzc #(
    .WIDTH(ExtW)
  ) u_lzc (
    .data (s2_q.sum[ExtW-1:0]),
    .count(lz)
  );

`ifdef FLOAT_ADDER_RNE_EN
  logic             rnd_inc;
  logic [MAN_W+1:0] sig_r;
  logic             unused_sig_r;
  assign unused_sig_r = sig_r[MAN_W];
`else
  logic             unused_norm;
  assign unused_norm = ^{norm[ExtW-1], norm[2:0]};
`endif

  // Underflow is judged on the normalised exponent, before the rounding carry.
  always_comb begin
    y_d   = '0;
    ovf_d = 1'b0;
    if (s2_q.sum[ExtW]) begin
      norm    = s2_q.sum[ExtW:1];
      norm[0] = s2_q.sum[1] | s2_q.sum[0];
      exp_n   = int'(s2_q.exp) + 1;
    end else begin
      norm  = s2_q.sum[ExtW-1:0] << lz;
      exp_n = int'(s2_q.exp) - int'(lz);
    end
`ifdef FLOAT_ADDER_RNE_EN
    rnd_inc = norm[2] & (norm[1] | norm[0] | norm[3]);
    sig_r   = {1'b0, norm[ExtW-1:3]} + (MAN_W+2)'(rnd_inc);
    if (sig_r[MAN_W+1]) begin
      exp_r   = exp_n + 1;
      man_out = '0;
    end else begin
      exp_r   = exp_n;
      man_out = sig_r[MAN_W-1:0];
    end
`else
    exp_r   = exp_n;
    man_out = norm[ExtW-2:3];
`endif
    if (s2_q.sum == '0) begin
      y_d = pack_fp(s2_q.zero_sign, '0, '0);
    end else if (exp_n <= 0) begin
      y_d = pack_fp(s2_q.sign, '0, '0);
    end else if (exp_r > exp_max(EXP_W)) begin
      y_d   = pack_fp(s2_q.sign, '1, '1);
      ovf_d = 1'b1;
    end else begin
      y_d = pack_fp(s2_q.sign, exp_r[EXP_W-1:0], man_out);
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q    <= 1'b0;
      out_y   <= '0;
      out_ovf <= 1'b0;
    end else if (adv3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        out_y   <= y_d;
        out_ovf <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_float_adder_pipe.sv
// Self-checking bench for float_adder_pipe (E4M3 default). Expected results come from an
// exact integer model of the format; honours FLOAT_ADDER_RNE_EN like the design.
module tb_float_adder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_sub;
  logic [7:0] in_a, in_b;
  logic       out_valid, out_ready;
  logic [7:0] out_y;
  logic       out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  float_adder_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sub   (in_sub),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

`ifdef FLOAT_ADDER_RNE_EN
  localparam logic [7:0] T4Exp = 8'h3A;
`else
  localparam logic [7:0] T4Exp = 8'h39;
`endif

  task automatic check_eq(input string tag, input int got, input int exp_v);
    n_checks++;
    if (got != exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
    end
  endtask

  // Exact sum in units of 2^-9 (value = 1.m * 2^(e-7)), then rounded to 4 significant bits.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic sub);
    int va, vb, sum, mag, p, e, sh, q, rem, half;
    logic sa, sb, s;
    sa = a[7];
    sb = b[7] ^ sub;
    va = (a[6:3] == 4'd0) ? 0 : (8 + int'(a[2:0])) << (int'(a[6:3]) - 1);
    vb = (b[6:3] == 4'd0) ? 0 : (8 + int'(b[2:0])) << (int'(b[6:3]) - 1);
    if (va == 0 && vb == 0) return {1'b0, sa & sb, 7'd0};
    sum = (sa ? -va : va) + (sb ? -vb : vb);
    if (sum == 0) return 9'd0;
    s   = (sum < 0);
    mag = s ? -sum : sum;
    p   = 0;
    for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
    e = p - 2;
    if (e <= 0) return {1'b0, s, 7'd0};
    sh  = p - 3;
    q   = mag >> sh;
    rem = mag - (q << sh);
`ifdef FLOAT_ADDER_RNE_EN
    if (sh > 0) begin
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
    end
    if (q == 16) begin
      q = 8;
      e++;
    end
`else
    rem = rem * 0;
`endif
    if (e > 15) return {1'b1, s, 7'h7F};
    return {1'b0, s, 4'(e), 3'(q - 8)};
  endfunction

  // One isolated operation through an empty pipe; checks latency and result.
  task automatic drive_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input logic [7:0] exp_y, input logic exp_ovf);
    int lat;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 3);
    check_eq({tag, "_y"}, out_y, exp_y);
    check_eq({tag, "_ovf"}, out_ovf, exp_ovf);
    @(posedge clk); #1;
  endtask

  logic [7:0] ops_a [30];
  logic [7:0] ops_b [30];
  logic       ops_s [30];
  logic [8:0] exp_q [$];
  logic [8:0] held;
  logic       hold_pending = 1'b0;
  int         tx, rx;

  // Random flow control; scoreboard in acceptance order. Called at posedge+1.
  task automatic stream(input int first, input int last, input bit drain);
    int idx, cyc;
    idx = first;
    cyc = 0;
    while ((idx < last || (drain && exp_q.size() != 0)) && cyc < 1000) begin
      if (idx < last) begin
        in_a = ops_a[idx]; in_b = ops_b[idx]; in_sub = ops_s[idx];
      end
      in_valid  = (idx < last) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (hold_pending) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", {out_ovf, out_y}, held);
      end
      hold_pending = out_valid && !out_ready;
      held = {out_ovf, out_y};
      if (out_valid && out_ready) begin
        rx++;
        check_eq("out_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check_eq($sformatf("rnd_rx%0d", rx), {out_ovf, out_y}, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(ops_a[idx], ops_b[idx], ops_s[idx]));
        tx++;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("stream_bound", int'(cyc < 1000), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sub = 1'b0;
    in_a = 8'h00; in_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_y", out_y, 0);
    check_eq("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready", in_ready, 1);

    drive_one("t1_add", 8'h38, 8'h38, 1'b0, 8'h40, 1'b0);
    drive_one("t2_sub", 8'h38, 8'h38, 1'b1, 8'h00, 1'b0);
    drive_one("t2_neg", 8'hB8, 8'h38, 1'b0, 8'h00, 1'b0);
    drive_one("t3_ab", 8'h3C, 8'h28, 1'b0, 8'h3E, 1'b0);
    drive_one("t3_ba", 8'h28, 8'h3C, 1'b0, 8'h3E, 1'b0);
    drive_one("t4_rnd", 8'h39, 8'h18, 1'b0, T4Exp, 1'b0);
    drive_one("t5_pos", 8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1);
    drive_one("t5_neg", 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b1);
    drive_one("z_pass", 8'h00, 8'h3C, 1'b1, 8'hBC, 1'b0);
    drive_one("z_both", 8'h80, 8'h00, 1'b1, 8'h80, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ops_a[i] = 8'($urandom);
      ops_b[i] = 8'($urandom);
      ops_s[i] = 1'($urandom);
    end

    // Full stream with backpressure.
    tx = 0; rx = 0;
    stream(0, 12, 1'b1);
    check_eq("p1_count", rx, tx);
    check_eq("p1_left", exp_q.size(), 0);

    // Partial stream, then reset with results in flight.
    stream(12, 18, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_y", out_y, 0);
    exp_q.delete();
    hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_quiet%0d", i), out_valid, 0);
      @(posedge clk); #1;
    end

    tx = 0; rx = 0;
    stream(18, 30, 1'b1);
    check_eq("p3_count", rx, tx);
    check_eq("p3_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
